// File: rtl/hash_collector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_collector_pkg                                                       |
// | Shared definitions for the hash collector: width helper, default table   |
// | depth, FSM state encoding, hash/occurrence field positions and the merge |
// | rule that decides what happens to a table entry on an incoming write.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package hash_collector_pkg;

  // Ceiling log2, never less than 1 so single-value fields still get a bit.
  function automatic int log2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Default table depth (1 << BIT_ON_TAILS with the default BIT_ON_TAILS).
  localparam int H = 1 << 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // An entry is {hash, occ}: occurrence in the low word, hash in the high word.
  localparam int OCC_LSB = 0;
  function automatic int hashLsb(input int w);
    return w;
  endfunction

  typedef enum logic [1:0] {
    MERGE_OVERWRITE = 2'd0,
    MERGE_ADD       = 2'd1,
    MERGE_KEEP      = 2'd2,
    MERGE_CONFLICT  = 2'd3
  } mergeAction_t;

  // Priority order matters: the first source always owns the slot, an empty
  // slot is claimed by anyone, a matching hash accumulates, an empty incoming
  // count is harmless, anything else is a collision.
  function automatic mergeAction_t mergeRule(input logic firstSrc,
                                             input logic storedOccZero,
                                             input logic hashMatch,
                                             input logic incomingOccZero);
    if (firstSrc || storedOccZero) return MERGE_OVERWRITE;
    if (hashMatch)                 return MERGE_ADD;
    if (incomingOccZero)           return MERGE_KEEP;
    return MERGE_CONFLICT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hash_collector_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_merge_unit                                                          |
// | Combinational merge of one incoming {hash, occ} entry into the stored    |
// | entry: compare, saturating occurrence add and collision flag.            |
// | Ports: i_k source index, i_stored current entry, i_incoming new entry,   |
// |        o_next value to write back, o_conflict collision indication.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hash_merge_unit
  import hash_collector_pkg::*;
#(
  parameter int W     = 32,
  parameter int SRC_W = 2
) (
  input  logic [SRC_W-1:0] i_k,
  input  logic [2*W-1:0]   i_stored,
  input  logic [2*W-1:0]   i_incoming,
  output logic [2*W-1:0]   o_next,
  output logic             o_conflict
);

  localparam int c_hashLsb = hashLsb(W);

  logic [W-1:0] w_storedHash;
  logic [W-1:0] w_storedOcc;
  logic [W-1:0] w_inHash;
  logic [W-1:0] w_inOcc;
  logic [W:0]   w_sum;
  logic [W-1:0] w_satOcc;
  mergeAction_t w_action;

  assign w_storedHash = i_stored[c_hashLsb +: W];
  assign w_storedOcc  = i_stored[OCC_LSB +: W];
  assign w_inHash     = i_incoming[c_hashLsb +: W];
  assign w_inOcc      = i_incoming[OCC_LSB +: W];

  // One extra bit catches the carry so the count pins at all-ones.
  assign w_sum    = {1'b0, w_storedOcc} + {1'b0, w_inOcc};
  assign w_satOcc = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];

  assign w_action = mergeRule(i_k == '0, w_storedOcc == '0,
                              w_storedHash == w_inHash, w_inOcc == '0);

  always_comb begin
    o_next     = i_stored;
    o_conflict = 1'b0;
    case (w_action)
      MERGE_OVERWRITE: o_next = i_incoming;
      MERGE_ADD:       o_next = {w_storedHash, w_satOcc};
      MERGE_CONFLICT:  o_conflict = 1'b1;
      default:         o_next = i_stored;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hash_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_collector                                                           |
// | Polls each upstream cache in turn, keeps the stream from source 0 and    |
// | merges every source's hash/occurrence table into one table.              |
// | Ports: clk/rst; Start; DataRequest/SrcSel/CacheEnough cache handshake;   |
// |        WrStreamData/AddrStreamData/StreamData stream write (1-based);    |
// |        WrHash/AddrHashOccurr/HashOccurr entry write (1-based);           |
// |        RdEn/RdAddr/RdHashOccurr registered table read;                   |
// |        RdStreamAddr/RdStreamData combinational stream read;              |
// |        Busy, Done, ConflictCount, StreamCount status.                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hash_collector
  import hash_collector_pkg::*;
#(
  parameter int LENGTH_ARRAY     = 100,
  parameter int NUM_PROCESSOR    = 3,
  parameter int DATA_INDEX_WIDTH = 32,
  parameter int BIT_ON_TAILS     = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  Start,
  output logic                                  DataRequest,
  output logic [log2(NUM_PROCESSOR)-1:0]        SrcSel,
  input  logic                                  CacheEnough,
  input  logic                                  WrStreamData,
  input  logic [log2(LENGTH_ARRAY)-1:0]         AddrStreamData,
  input  logic [DATA_INDEX_WIDTH-1:0]           StreamData,
  input  logic                                  WrHash,
  input  logic [log2(2*(1<<BIT_ON_TAILS))-1:0]  AddrHashOccurr,
  input  logic [2*DATA_INDEX_WIDTH-1:0]         HashOccurr,
  input  logic                                  RdEn,
  input  logic [BIT_ON_TAILS-1:0]               RdAddr,
  output logic [2*DATA_INDEX_WIDTH-1:0]         RdHashOccurr,
  input  logic [log2(LENGTH_ARRAY)-1:0]         RdStreamAddr,
  output logic [DATA_INDEX_WIDTH-1:0]           RdStreamData,
  output logic                                  Busy,
  output logic                                  Done,
  output logic [15:0]                           ConflictCount,
  output logic [log2(LENGTH_ARRAY+1)-1:0]       StreamCount
);

  localparam int c_w         = DATA_INDEX_WIDTH;
  localparam int c_depth     = 1 << BIT_ON_TAILS;
  localparam int c_srcW      = log2(NUM_PROCESSOR);
  localparam int c_strAddrW  = log2(LENGTH_ARRAY);
  localparam int c_hashAddrW = log2(2 * c_depth);
  localparam int c_cntW      = log2(LENGTH_ARRAY + 1);
  localparam logic [c_srcW-1:0] c_lastSrc = c_srcW'(NUM_PROCESSOR - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [c_srcW-1:0]   r_k;
  logic [c_srcW-1:0]   w_nextK;
  logic                w_startRun;
  logic                r_dataRequest;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_conflictCount;
  logic [c_cntW-1:0]   r_streamCount;
  logic [2*c_w-1:0]    r_rdHashOccurr;

  logic [c_w-1:0]      r_streamMem [0:LENGTH_ARRAY-1];
  logic [2*c_w-1:0]    r_hashMem   [0:c_depth-1];

  logic [c_hashAddrW-1:0]  w_hashIdxFull;
  logic [BIT_ON_TAILS-1:0] w_hashIdx;
  logic                    w_hashWe;
  logic [c_strAddrW-1:0]   w_strIdx;
  logic                    w_streamWe;
  logic                    w_inReq;
  logic [2*c_w-1:0]        w_mergeNext;
  logic                    w_mergeConflict;

  assign w_inReq = (r_state == ST_REQ) && !rst;

  // 1-based addresses: 0 underflows and anything past the depth is dropped.
  // The comparison uses the full-width index so no address aliases onto a slot.
  assign w_hashIdxFull = AddrHashOccurr - c_hashAddrW'(1);
  assign w_hashIdx     = w_hashIdxFull[BIT_ON_TAILS-1:0];
  assign w_hashWe      = w_inReq && WrHash && (AddrHashOccurr != '0) &&
                         (w_hashIdxFull < c_hashAddrW'(c_depth));

  assign w_strIdx   = AddrStreamData - c_strAddrW'(1);
  assign w_streamWe = w_inReq && WrStreamData && (r_k == '0) &&
                      (AddrStreamData != '0) &&
                      ({1'b0, w_strIdx} < (c_strAddrW+1)'(LENGTH_ARRAY));

  hash_merge_unit #(
    .W     (c_w),
    .SRC_W (c_srcW)
  ) u_merge (
    .i_k        (r_k),
    .i_stored   (r_hashMem[w_hashIdx]),
    .i_incoming (HashOccurr),
    .o_next     (w_mergeNext),
    .o_conflict (w_mergeConflict)
  );

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    w_nextK     = r_k;
    w_startRun  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_nextState = ST_REQ;
          w_nextK     = '0;
          w_startRun  = 1'b1;
        end
      end
      ST_REQ: begin
        if (CacheEnough) w_nextState = ST_DROP;
      end
      ST_DROP: begin
        if (r_k < c_lastSrc) begin
          w_nextK     = r_k + c_srcW'(1);
          w_nextState = ST_REQ;
        end else begin
          w_nextState = ST_DONE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register; handshake outputs are registered from the next state so
  // DataRequest drops in the same cycle the FSM leaves REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_dataRequest <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_k           <= w_nextK;
      r_dataRequest <= (w_nextState == ST_REQ);
      r_busy        <= (w_nextState == ST_REQ) || (w_nextState == ST_DROP);
      r_done        <= (w_nextState == ST_DONE);
    end
  end

  // Counters and registered table read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflictCount <= '0;
      r_streamCount   <= '0;
      r_rdHashOccurr  <= '0;
    end else begin
      if (w_startRun) begin
        r_conflictCount <= '0;
        r_streamCount   <= '0;
      end else begin
        if (w_hashWe && w_mergeConflict && (r_conflictCount != 16'hFFFF))
          r_conflictCount <= r_conflictCount + 16'd1;
        if (w_streamWe && (r_streamCount != '1))
          r_streamCount <= r_streamCount + c_cntW'(1);
      end
      // Non-blocking read sees the pre-write value of a same-cycle merge.
      if (RdEn) r_rdHashOccurr <= r_hashMem[RdAddr];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_hashWe)   r_hashMem[w_hashIdx]  <= w_mergeNext;
    if (w_streamWe) r_streamMem[w_strIdx] <= StreamData;
  end

  assign RdStreamData = ({1'b0, RdStreamAddr} < (c_strAddrW+1)'(LENGTH_ARRAY)) ?
                        r_streamMem[RdStreamAddr] : '0;

  assign DataRequest   = r_dataRequest;
  assign SrcSel        = r_k;
  assign Busy          = r_busy;
  assign Done          = r_done;
  assign ConflictCount = r_conflictCount;
  assign StreamCount   = r_streamCount;
  assign RdHashOccurr  = r_rdHashOccurr;

endmodule
`default_nettype wire

// File: tb/tb_hash_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hash_collector                                                        |
// | Self-checking bench: cache-side driver, reference model of the merged    |
// | table/stream/status, a per-cycle compare process and literal checks.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hash_collector;

  localparam int c_len   = 100;
  localparam int c_np    = 3;
  localparam int c_depth = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic        DataRequest;
  logic [1:0]  SrcSel;
  logic        CacheEnough = 1'b0;
  logic        WrStreamData = 1'b0;
  logic [6:0]  AddrStreamData = '0;
  logic [31:0] StreamData = '0;
  logic        WrHash = 1'b0;
  logic [7:0]  AddrHashOccurr = '0;
  logic [63:0] HashOccurr = '0;
  logic        RdEn = 1'b0;
  logic [6:0]  RdAddr = '0;
  logic [63:0] RdHashOccurr;
  logic [6:0]  RdStreamAddr = '0;
  logic [31:0] RdStreamData;
  logic        Busy;
  logic        Done;
  logic [15:0] ConflictCount;
  logic [6:0]  StreamCount;

  always #5 clk = ~clk;

  hash_collector dut (
    .clk(clk), .rst(rst), .Start(Start),
    .DataRequest(DataRequest), .SrcSel(SrcSel), .CacheEnough(CacheEnough),
    .WrStreamData(WrStreamData), .AddrStreamData(AddrStreamData), .StreamData(StreamData),
    .WrHash(WrHash), .AddrHashOccurr(AddrHashOccurr), .HashOccurr(HashOccurr),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdHashOccurr(RdHashOccurr),
    .RdStreamAddr(RdStreamAddr), .RdStreamData(RdStreamData),
    .Busy(Busy), .Done(Done), .ConflictCount(ConflictCount), .StreamCount(StreamCount)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mTbl [c_depth];
  bit          mTblKnown [c_depth];
  logic [31:0] mStr [c_len];
  bit          mStrKnown [c_len];
  bit          mActive, mRewind, mFinished;
  int          mSrc, mConf, mSc, mA;
  logic [63:0] mRd;
  bit          mRdKnown;

  task automatic modelMerge(input int e, input logic [63:0] v);
    logic [31:0] sh, so, ih, io;
    longint unsigned sum;
    sh = mTbl[e][63:32]; so = mTbl[e][31:0];
    ih = v[63:32];       io = v[31:0];
    if (mSrc == 0 || so == 0) begin
      mTbl[e] = v;
      mTblKnown[e] = 1'b1;
    end else if (sh == ih) begin
      sum = longint'(so) + longint'(io);
      if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
      mTbl[e] = {sh, sum[31:0]};
    end else if (io == 0) begin
      mTbl[e] = mTbl[e];
    end else if (mConf < 65535) begin
      mConf++;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mActive = 0; mRewind = 0; mFinished = 0; mSrc = 0;
      mConf = 0; mSc = 0; mRd = '0; mRdKnown = 1;
    end else begin
      if (RdEn) begin
        mRd = mTbl[RdAddr];
        mRdKnown = mTblKnown[RdAddr];
      end
      if (mActive) begin
        mA = int'(AddrStreamData);
        if (WrStreamData && mSrc == 0 && mA >= 1 && mA <= c_len) begin
          mStr[mA-1] = StreamData;
          mStrKnown[mA-1] = 1'b1;
          mSc++;
        end
        mA = int'(AddrHashOccurr);
        if (WrHash && mA >= 1 && mA <= c_depth) modelMerge(mA - 1, HashOccurr);
        if (CacheEnough) begin mActive = 0; mRewind = 1; end
      end else if (mRewind) begin
        mRewind = 0;
        if (mSrc < c_np - 1) begin mSrc++; mActive = 1; end
        else mFinished = 1;
      end else if (Start) begin
        mActive = 1; mFinished = 0; mSrc = 0; mConf = 0; mSc = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("DataRequest", 64'(DataRequest), 64'(mActive));
      check("Busy", 64'(Busy), 64'(mActive || mRewind));
      check("Done", 64'(Done), 64'(mFinished));
      check("ConflictCount", 64'(ConflictCount), 64'(mConf));
      check("StreamCount", 64'(StreamCount), 64'(mSc));
      if (mActive) check("SrcSel", 64'(SrcSel), 64'(mSrc));
      if (mRdKnown) check("RdHashOccurr", RdHashOccurr, mRd);
      if (int'(RdStreamAddr) < c_len && mStrKnown[RdStreamAddr])
        check("RdStreamData", 64'(RdStreamData), 64'(mStr[RdStreamAddr]));
    end
  end

  // ---------------- cache-side driver ----------------
  logic [7:0]  drvAddr [c_depth];
  logic [31:0] drvHash [c_depth];
  logic [31:0] drvOcc  [c_depth];
  logic [31:0] drvStr  [c_len];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input int mode, input int src);
    for (int i = 0; i < c_depth; i++) begin
      drvAddr[i] = 8'(i + 1); drvHash[i] = 32'(i); drvOcc[i] = 32'd1;
    end
    for (int j = 0; j < c_len; j++) drvStr[j] = (src == 0) ? 32'(j + 1) : 32'(900 + j);
    if (mode == 1) begin
      case (src)
        0: begin
          drvHash[4] = 32'd7;  drvOcc[4] = 32'd10;
          drvOcc[10] = 32'hFFFF_FFFE;
        end
        1: begin
          drvHash[4] = 32'd5;  drvOcc[4] = 32'd2;
          drvOcc[10] = 32'd5;
        end
        default: begin
          drvHash[4] = 32'd7;  drvOcc[4] = 32'd3;
          drvHash[20] = 32'd99; drvOcc[20] = 32'd0;
          drvAddr[50] = 8'd0;   drvHash[50] = 32'h55;
          drvAddr[60] = 8'd129; drvHash[60] = 32'h77;
        end
      endcase
    end
  endtask

  task automatic waitReq(input int src, output bit ok);
    ok = 0;
    for (int n = 0; n < 1000; n++) begin
      if (DataRequest && SrcSel == 2'(src)) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL waitReq src=%0d actual=timeout required=DataRequest", src);
    end
  endtask

  // abortAt/startAt/rdAt: transfer index at which to assert rst, pulse Start,
  // or read back the entry being written (-1 disables).
  task automatic runSource(input int src, input int abortAt, input int startAt,
                           input int rdAt, output bit aborted);
    bit ok;
    aborted = 0;
    waitReq(src, ok);
    if (!ok) return;
    for (int i = 0; i < c_depth; i++) begin
      tick();
      if (i == abortAt) begin
        WrHash = 0; WrStreamData = 0; Start = 0; RdEn = 0;
        rst = 1; aborted = 1;
        return;
      end
      WrHash = 1; AddrHashOccurr = drvAddr[i]; HashOccurr = {drvHash[i], drvOcc[i]};
      WrStreamData = (i < c_len);
      AddrStreamData = (i < c_len) ? 7'(i + 1) : 7'd0;
      StreamData = (i < c_len) ? drvStr[i] : 32'd0;
      CacheEnough = (i == c_depth - 1);
      Start = (i == startAt);
      RdEn = (i == rdAt); RdAddr = 7'(i);
    end
    tick();
    WrHash = 0; WrStreamData = 0; CacheEnough = 0; Start = 0; RdEn = 0;
  endtask

  task automatic runRun(input int mode, input int abortSrc, input int abortAt,
                        output int len, output bit aborted);
    int t0;
    Start = 1;
    tick();
    Start = 0;
    t0 = cyc;
    len = 0;
    aborted = 0;
    for (int s = 0; s < c_np; s++) begin
      fill(mode, s);
      runSource(s, (s == abortSrc) ? abortAt : -1, (s == 1) ? 30 : -1,
                (s == 2) ? 70 : -1, aborted);
      if (aborted) return;
    end
    for (int n = 0; n < 50 && !Done; n++) tick();
    if (!Done) begin
      checks++; errors++;
      $display("FAIL waitDone actual=timeout required=Done");
    end
    len = cyc - t0;
  endtask

  task automatic readEntry(input int idx, input logic [63:0] exp, input string name);
    RdEn = 1; RdAddr = 7'(idx);
    tick();
    RdEn = 0;
    check(name, RdHashOccurr, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int len;
    bit ab;
    repeat (3) tick();
    rst = 0;
    tick();
    check("reset DataRequest", 64'(DataRequest), 64'd0);
    check("reset Busy", 64'(Busy), 64'd0);
    check("reset Done", 64'(Done), 64'd0);
    check("reset SrcSel", 64'(SrcSel), 64'd0);
    check("reset ConflictCount", 64'(ConflictCount), 64'd0);
    check("reset StreamCount", 64'(StreamCount), 64'd0);
    check("reset RdHashOccurr", RdHashOccurr, 64'd0);

    // Run 1: uniform tables, one copy of the stream, Start while busy ignored
    runRun(0, -1, -1, len, ab);
    check("run1 length", 64'(len), 64'd390);
    check("run1 Done", 64'(Done), 64'd1);
    check("run1 ConflictCount", 64'(ConflictCount), 64'd0);
    check("run1 StreamCount", 64'(StreamCount), 64'd100);
    for (int i = 0; i < c_depth; i++)
      readEntry(i, {32'(i), 32'd3}, $sformatf("run1 entry%0d", i));
    RdStreamAddr = 7'd0;  #1; check("stream[0]", 64'(RdStreamData), 64'd1);
    RdStreamAddr = 7'd49; #1; check("stream[49]", 64'(RdStreamData), 64'd50);
    RdStreamAddr = 7'd99; #1; check("stream[99]", 64'(RdStreamData), 64'd100);

    // WrHash outside REQ leaves the table alone
    WrHash = 1; AddrHashOccurr = 8'd1; HashOccurr = {32'hDEAD, 32'd9};
    tick();
    WrHash = 0;
    readEntry(0, {32'd0, 32'd3}, "done-state write ignored");

    // Run 2: conflict, saturation, zero occurrence, bad addresses
    runRun(1, -1, -1, len, ab);
    check("run2 ConflictCount", 64'(ConflictCount), 64'd1);
    readEntry(4,  {32'd7,  32'd13},          "conflict entry4");
    readEntry(10, {32'd10, 32'hFFFF_FFFF},   "saturated entry10");
    readEntry(20, {32'd20, 32'd2},           "zero-occ entry20");
    readEntry(50, {32'd50, 32'd2},           "addr0 entry50");
    readEntry(60, {32'd60, 32'd2},           "addr129 entry60");
    readEntry(0,  {32'd0,  32'd3},           "addr129 no alias entry0");
    readEntry(1,  {32'd1,  32'd3},           "run2 entry1");

    // Run 3: reset in the middle of source 1
    runRun(0, 1, 20, len, ab);
    check("abort reached", 64'(ab), 64'd1);
    tick();
    rst = 0;
    check("abort DataRequest", 64'(DataRequest), 64'd0);
    check("abort Busy", 64'(Busy), 64'd0);
    check("abort Done", 64'(Done), 64'd0);

    // Run 4: clean run after the abort
    runRun(0, -1, -1, len, ab);
    check("run4 length", 64'(len), 64'd390);
    check("run4 StreamCount", 64'(StreamCount), 64'd100);
    readEntry(0,   {32'd0,   32'd3}, "run4 entry0");
    readEntry(4,   {32'd4,   32'd3}, "run4 entry4");
    readEntry(127, {32'd127, 32'd3}, "run4 entry127");

    // WrHash in IDLE after reset
    rst = 1;
    tick();
    rst = 0;
    WrHash = 1; AddrHashOccurr = 8'd1; HashOccurr = {32'hDEAD, 32'd9};
    tick();
    WrHash = 0;
    readEntry(0, {32'd0, 32'd3}, "idle write ignored");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
